// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitGnt = 2'd1,
    StWaitRsp = 2'd2,
    StDone    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  // Access size from funct3. The unsigned variants share the low bits with the signed
  // ones, and the unused codes (011/110/111) fall through to word.
  function automatic size_e access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SzByte;
      2'b01:   return SzHalf;
      default: return SzWord;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Extracts the addressed lane of a read word and sign/zero-extends it.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  // Shift the addressed byte to bit 0, then extend according to funct3.
  always_comb begin
    lane = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data_o = {24'd0, lane[7:0]};
      F3_HU:   data_o = {16'd0, lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues req/gnt/rvalid bus transactions for loads and
// stores, stalls the upstream pipeline while an access is outstanding and aligns load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic [2:0]            funct3_in,
  input  logic [DATA_WIDTH-1:0] ALU_result_in,
  input  logic [DATA_WIDTH-1:0] store_data_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  stall_o,
  output logic                  misaligned_o
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic [DATA_WIDTH-1:0] load_data_q;

  logic                  acc, misaligned, start;
  logic [1:0]            offset;
  size_e                 size;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic [3:0]            be_calc;
  logic [DATA_WIDTH-1:0] wdata_calc;
  logic [DATA_WIDTH-1:0] aligned;

  // Decode the instruction currently in EX/MEM into bus request fields.
  always_comb begin
    acc        = MemRead_in | MemWrite_in;
    offset     = ALU_result_in[1:0];
    size       = access_size(funct3_in);
    misaligned = ((size == SzHalf) && offset[0]) || ((size == SzWord) && (offset != 2'b00));
    start      = acc & ~misaligned;
    addr_calc  = {ALU_result_in[ADDR_WIDTH-1:2], 2'b00};
    unique case (size)
      SzByte: begin
        be_calc    = 4'b0001 << offset;
        wdata_calc = {4{store_data_in[7:0]}};
      end
      SzHalf: begin
        be_calc    = 4'b0011 << offset;
        wdata_calc = {2{store_data_in[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = store_data_in;
      end
    endcase
  end

  // Next state and bus/pipeline outputs; outside IDLE the latched request is presented.
  always_comb begin
    state_d      = state_q;
    dmem_req     = 1'b0;
    stall_o      = 1'b0;
    misaligned_o = 1'b0;
    dmem_we      = we_q;
    dmem_addr    = addr_q;
    dmem_be      = be_q;
    dmem_wdata   = wdata_q;
    unique case (state_q)
      StIdle: begin
        misaligned_o = acc & misaligned;
        if (start) begin
          dmem_req   = 1'b1;
          stall_o    = 1'b1;
          dmem_we    = MemWrite_in;
          dmem_addr  = addr_calc;
          dmem_be    = be_calc;
          dmem_wdata = wdata_calc;
          state_d    = dmem_gnt ? StWaitRsp : StWaitGnt;
        end
      end
      StWaitGnt: begin
        dmem_req = 1'b1;
        stall_o  = 1'b1;
        if (dmem_gnt) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        stall_o = 1'b1;
        if (dmem_rvalid) state_d = StDone;
      end
      // EX/MEM still holds the finished instruction here, so no request is raised.
      default: state_d = StIdle;
    endcase
  end

  mem_access_unit_load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (aligned)
  );

  // State, latched request fields and the load result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        addr_q   <= addr_calc;
        we_q     <= MemWrite_in;
        be_q     <= be_calc;
        wdata_q  <= wdata_calc;
        funct3_q <= funct3_in;
        offset_q <= offset;
      end
      if (state_q == StWaitRsp && dmem_rvalid && !we_q) begin
        load_data_q <= aligned;
      end
    end
  end

  assign load_data_o = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an expected-result queue for load_data_o.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in;
  logic [2:0]  funct3_in;
  logic [31:0] ALU_result_in, store_data_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data_o;
  logic        stall_o, misaligned_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .MemRead_in    (MemRead_in),
    .MemWrite_in   (MemWrite_in),
    .funct3_in     (funct3_in),
    .ALU_result_in (ALU_result_in),
    .store_data_in (store_data_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .load_data_o   (load_data_o),
    .stall_o       (stall_o),
    .misaligned_o  (misaligned_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
  endtask

  // One complete access starting in IDLE; gnt arrives gnt_dly cycles after the request
  // and rvalid the cycle after gnt. Returns in the IDLE that follows DONE.
  task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int gnt_dly,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_ld);
    logic [31:0] exp_addr;
    exp_addr      = {a[31:2], 2'b00};
    MemRead_in    = ~wr;
    MemWrite_in   = wr;
    funct3_in     = f3;
    ALU_result_in = a;
    store_data_in = wd;
    exp_q.push_back(exp_ld);
    for (int i = 0; i <= gnt_dly; i++) begin
      dmem_gnt = (i == gnt_dly);
      if (i > 0) begin
        // Upstream is stalled, but the bus must still present the latched request.
        ALU_result_in = a ^ 32'h0000_0F00;
        store_data_in = ~wd;
      end
      #1;
      chk({tag, " req"},   dmem_req, 1'b1);
      chk({tag, " stall"}, stall_o, 1'b1);
      chk({tag, " addr"},  dmem_addr, exp_addr);
      chk({tag, " be"},    dmem_be, exp_be);
      chk({tag, " we"},    dmem_we, wr);
      chk({tag, " wdata"}, dmem_wdata, exp_wd);
      chk({tag, " misal"}, misaligned_o, 1'b0);
      tick();
    end
    ALU_result_in = a;
    store_data_in = wd;
    dmem_gnt      = 1'b0;
    dmem_rvalid   = 1'b1;
    dmem_rdata    = rdata;
    #1;
    chk({tag, " rsp req"},   dmem_req, 1'b0);
    chk({tag, " rsp stall"}, stall_o, 1'b1);
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    #1;
    chk({tag, " done stall"}, stall_o, 1'b0);
    chk({tag, " done req"},   dmem_req, 1'b0);
    if (exp_q.size() == 0) chk({tag, " sb empty"}, 32'd0, 32'd1);
    else chk({tag, " load_data"}, load_data_o, exp_q.pop_front());
    tick();
    idle_inputs();
  endtask

  initial begin
    rst           = 1'b1;
    idle_inputs();
    funct3_in     = 3'b000;
    ALU_result_in = 32'h0;
    store_data_in = 32'h0;
    dmem_gnt      = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = 32'h0;
    repeat (2) tick();
    chk("rst req", dmem_req, 1'b0);
    chk("rst stall", stall_o, 1'b0);
    chk("rst load_data", load_data_o, 32'h0);
    chk("rst be", dmem_be, 4'h0);
    chk("rst addr", dmem_addr, 32'h0);
    rst = 1'b0;
    tick();

    access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000, 4'b1000, 32'h0, 32'h0000_0080);
    access("sh", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 32'hFFFF_FFFF, 4'b1100,
           32'hABCD_ABCD, 32'h0000_0080);

    // Misaligned word: flagged, no request, no stall, result held.
    MemRead_in    = 1'b1;
    funct3_in     = 3'b010;
    ALU_result_in = 32'h101;
    dmem_gnt      = 1'b1;
    #1;
    chk("misal flag", misaligned_o, 1'b1);
    chk("misal req", dmem_req, 1'b0);
    chk("misal stall", stall_o, 1'b0);
    tick();
    chk("misal hold stall", stall_o, 1'b0);
    chk("misal load_data", load_data_o, 32'h0000_0080);
    dmem_gnt = 1'b0;
    idle_inputs();

    access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001);

    // Reset while waiting for the response.
    MemRead_in    = 1'b1;
    funct3_in     = 3'b010;
    ALU_result_in = 32'h40;
    dmem_gnt      = 1'b1;
    #1;
    chk("pre-rst req", dmem_req, 1'b1);
    tick();
    dmem_gnt    = 1'b0;
    rst         = 1'b1;
    idle_inputs();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    #1;
    chk("midrst stall", stall_o, 1'b0);
    chk("midrst req", dmem_req, 1'b0);
    chk("midrst load_data", load_data_o, 32'h0);
    chk("midrst be", dmem_be, 4'h0);
    chk("midrst addr", dmem_addr, 32'h0);
    chk("midrst wdata", dmem_wdata, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("late rvalid load_data", load_data_o, 32'h0);
    chk("late rvalid stall", stall_o, 1'b0);

    access("lw2", 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h5555_AAAA, 4'b1111, 32'h0, 32'h5555_AAAA);

    // Back-to-back: the store is issued in the IDLE right after the load's DONE.
    access("b2b lw", 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h0BAD_F00D, 4'b1111, 32'h0,
           32'h0BAD_F00D);
    access("b2b sw", 1'b1, 3'b010, 32'h14, 32'hCAFE_0001, 2, 32'h0, 4'b1111, 32'hCAFE_0001,
           32'h0BAD_F00D);

    // Non-memory instruction.
    #1;
    chk("nop req", dmem_req, 1'b0);
    chk("nop stall", stall_o, 1'b0);
    chk("nop load_data", load_data_o, 32'h0BAD_F00D);
    chk("sb drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
